// File: rtl/vga_timing_gen_if.sv
// Pixel-timing bus between vga_timing_gen (master) and the draw pipeline (slave).
// Carries the stall/mode controls in and the counters plus strobes out.
interface vga_timing_gen_if #(
    parameter int unsigned CNT_W = 11
) ();
    logic             pix_en;
    logic             mode_sel;
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    logic             frame_start;
    logic             active_mode;

    modport master (
        input  pix_en,
        input  mode_sel,
        output hcount,
        output vcount,
        output hsync,
        output vsync,
        output hblnk,
        output vblnk,
        output frame_start,
        output active_mode
    );

    modport slave (
        output pix_en,
        output mode_sel,
        input  hcount,
        input  vcount,
        input  hsync,
        input  vsync,
        input  hblnk,
        input  vblnk,
        input  frame_start,
        input  active_mode
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Two-mode VGA timing generator: counters, sync/blank strobes and frame-start pulse.
// Mode changes are latched only at the end-of-frame wrap.
module vga_timing_gen #(
    parameter int unsigned CNT_W        = 11,
    parameter bit          DEFAULT_MODE = 1'b0,
    parameter int unsigned M0_H_ACTIVE  = 1024,
    parameter int unsigned M0_H_TOTAL   = 1344,
    parameter int unsigned M0_HS_START  = 1048,
    parameter int unsigned M0_HS_END    = 1183,
    parameter int unsigned M0_V_ACTIVE  = 768,
    parameter int unsigned M0_V_TOTAL   = 806,
    parameter int unsigned M0_VS_START  = 771,
    parameter int unsigned M0_VS_END    = 776,
    parameter bit          M0_HS_POL    = 1'b0,
    parameter bit          M0_VS_POL    = 1'b0,
    parameter int unsigned M1_H_ACTIVE  = 800,
    parameter int unsigned M1_H_TOTAL   = 1056,
    parameter int unsigned M1_HS_START  = 840,
    parameter int unsigned M1_HS_END    = 967,
    parameter int unsigned M1_V_ACTIVE  = 600,
    parameter int unsigned M1_V_TOTAL   = 628,
    parameter int unsigned M1_VS_START  = 601,
    parameter int unsigned M1_VS_END    = 604,
    parameter bit          M1_HS_POL    = 1'b1,
    parameter bit          M1_VS_POL    = 1'b1
) (
    input logic              clk,
    input logic              rst,
    vga_timing_gen_if.master bus
);
    typedef logic [CNT_W-1:0] cnt_t;

    localparam int unsigned MaxTotal = (CNT_W >= 32) ? 32'hFFFF_FFFF : (32'd1 << CNT_W);

    if (M0_H_TOTAL > MaxTotal || M0_V_TOTAL > MaxTotal ||
        M1_H_TOTAL > MaxTotal || M1_V_TOTAL > MaxTotal) begin : g_bad_width
        $error("vga_timing_gen: a TOTAL does not fit in CNT_W bits");
    end
    if (!(M0_HS_START <= M0_HS_END && M0_HS_END < M0_H_TOTAL) ||
        !(M0_VS_START <= M0_VS_END && M0_VS_END < M0_V_TOTAL)) begin : g_bad_mode0
        $error("vga_timing_gen: mode 0 sync window out of range");
    end
    if (!(M1_HS_START <= M1_HS_END && M1_HS_END < M1_H_TOTAL) ||
        !(M1_VS_START <= M1_VS_END && M1_VS_END < M1_V_TOTAL)) begin : g_bad_mode1
        $error("vga_timing_gen: mode 1 sync window out of range");
    end

    // Per-mode timing tables, indexed by the mode bit.
    localparam cnt_t HLast   [2] = '{cnt_t'(M0_H_TOTAL - 1), cnt_t'(M1_H_TOTAL - 1)};
    localparam cnt_t VLast   [2] = '{cnt_t'(M0_V_TOTAL - 1), cnt_t'(M1_V_TOTAL - 1)};
    localparam cnt_t HAct    [2] = '{cnt_t'(M0_H_ACTIVE), cnt_t'(M1_H_ACTIVE)};
    localparam cnt_t VAct    [2] = '{cnt_t'(M0_V_ACTIVE), cnt_t'(M1_V_ACTIVE)};
    localparam cnt_t HsStart [2] = '{cnt_t'(M0_HS_START), cnt_t'(M1_HS_START)};
    localparam cnt_t HsEnd   [2] = '{cnt_t'(M0_HS_END), cnt_t'(M1_HS_END)};
    localparam cnt_t VsStart [2] = '{cnt_t'(M0_VS_START), cnt_t'(M1_VS_START)};
    localparam cnt_t VsEnd   [2] = '{cnt_t'(M0_VS_END), cnt_t'(M1_VS_END)};
    localparam logic [1:0] HsPol = {M1_HS_POL, M0_HS_POL};
    localparam logic [1:0] VsPol = {M1_VS_POL, M0_VS_POL};

    cnt_t hcount_q, hcount_d;
    cnt_t vcount_q, vcount_d;
    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic hblnk_q, hblnk_d;
    logic vblnk_q, vblnk_d;
    logic frame_start_q, frame_start_d;
    logic mode_q, mode_d;
    logic end_of_line, end_of_frame;

    always_comb begin
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        hblnk_d       = hblnk_q;
        vblnk_d       = vblnk_q;
        mode_d        = mode_q;
        frame_start_d = 1'b0;
        end_of_line   = (hcount_q == HLast[mode_q]);
        end_of_frame  = end_of_line && (vcount_q == VLast[mode_q]);

        if (bus.pix_en) begin
            frame_start_d = end_of_frame;
            if (end_of_frame) begin
                mode_d   = bus.mode_sel;
                hcount_d = '0;
                vcount_d = '0;
            end else if (end_of_line) begin
                hcount_d = '0;
                vcount_d = vcount_q + cnt_t'(1);
            end else begin
                hcount_d = hcount_q + cnt_t'(1);
            end
            // Decode from the next count and next mode so strobes line up with the counters.
            hsync_d = (hcount_d >= HsStart[mode_d] && hcount_d <= HsEnd[mode_d]) ?
                      HsPol[mode_d] : ~HsPol[mode_d];
            vsync_d = (vcount_d >= VsStart[mode_d] && vcount_d <= VsEnd[mode_d]) ?
                      VsPol[mode_d] : ~VsPol[mode_d];
            hblnk_d = (hcount_d >= HAct[mode_d]);
            vblnk_d = (vcount_d >= VAct[mode_d]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= ~HsPol[DEFAULT_MODE];
            vsync_q       <= ~VsPol[DEFAULT_MODE];
            hblnk_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            frame_start_q <= 1'b0;
            mode_q        <= DEFAULT_MODE;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hblnk_q       <= hblnk_d;
            vblnk_q       <= vblnk_d;
            frame_start_q <= frame_start_d;
            mode_q        <= mode_d;
        end
    end

    assign bus.hcount      = hcount_q;
    assign bus.vcount      = vcount_q;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.hblnk       = hblnk_q;
    assign bus.vblnk       = vblnk_q;
    assign bus.frame_start = frame_start_q;
    assign bus.active_mode = mode_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance for line-level checks and a
// shrunken-timing instance for frame-level, mode-switch, reset and random checks.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    bit   chk_en = 1'b0;
    int   checks = 0;
    int   failures = 0;

    vga_timing_gen_if #(.CNT_W(11)) ifa ();
    vga_timing_gen_if #(.CNT_W(5))  ifb ();

    vga_timing_gen dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ifa.master)
    );

    vga_timing_gen #(
        .CNT_W(5), .DEFAULT_MODE(1'b0),
        .M0_H_ACTIVE(16), .M0_H_TOTAL(24), .M0_HS_START(18), .M0_HS_END(20),
        .M0_V_ACTIVE(10), .M0_V_TOTAL(14), .M0_VS_START(11), .M0_VS_END(12),
        .M0_HS_POL(1'b0), .M0_VS_POL(1'b0),
        .M1_H_ACTIVE(12), .M1_H_TOTAL(20), .M1_HS_START(13), .M1_HS_END(15),
        .M1_V_ACTIVE(8), .M1_V_TOTAL(11), .M1_VS_START(9), .M1_VS_END(9),
        .M1_HS_POL(1'b1), .M1_VS_POL(1'b1)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ifb.master)
    );

    typedef struct {
        int unsigned ha, ht, hss, hse, va, vt, vss, vse;
        bit          hp, vp;
    } mode_cfg_t;

    mode_cfg_t ca [2];
    mode_cfg_t cb [2];

    // Reference model: linear pixel index within the frame plus latched mode.
    int unsigned pa = 0, pb = 0;
    bit          ma = 1'b0, mb = 1'b0, fa = 1'b0, fb = 1'b0;

    always @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            pa <= 0; ma <= 1'b0; fa <= 1'b0;
        end else if (ifa.pix_en) begin
            if (pa == ca[ma].ht * ca[ma].vt - 1) begin
                pa <= 0; ma <= ifa.mode_sel; fa <= 1'b1;
            end else begin
                pa <= pa + 1; fa <= 1'b0;
            end
        end else begin
            fa <= 1'b0;
        end
    end

    always @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            pb <= 0; mb <= 1'b0; fb <= 1'b0;
        end else if (ifb.pix_en) begin
            if (pb == cb[mb].ht * cb[mb].vt - 1) begin
                pb <= 0; mb <= ifb.mode_sel; fb <= 1'b1;
            end else begin
                pb <= pb + 1; fb <= 1'b0;
            end
        end else begin
            fb <= 1'b0;
        end
    end

    function automatic logic [37:0] expect_pack(mode_cfg_t c, int unsigned p, bit m, bit fs);
        int unsigned h, v;
        logic        hs, vs;
        h  = p % c.ht;
        v  = p / c.ht;
        hs = (h >= c.hss && h <= c.hse) ? c.hp : !c.hp;
        vs = (v >= c.vss && v <= c.vse) ? c.vp : !c.vp;
        return {16'(h), 16'(v), hs, vs, (h >= c.ha), (v >= c.va), fs, m};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("a_model", {16'(ifa.hcount), 16'(ifa.vcount), ifa.hsync, ifa.vsync,
                              ifa.hblnk, ifa.vblnk, ifa.frame_start, ifa.active_mode},
                  expect_pack(ca[ma], pa, ma, fa));
            check("b_model", {16'(ifb.hcount), 16'(ifb.vcount), ifb.hsync, ifb.vsync,
                              ifb.hblnk, ifb.vblnk, ifb.frame_start, ifb.active_mode},
                  expect_pack(cb[mb], pb, mb, fb));
        end
    end

    task automatic run_a(input bit en, input int n);
        ifa.pix_en = en;
        repeat (n) @(negedge clk);
    endtask

    task automatic step_b(input int n);
        ifb.pix_en = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Advance dut_b until frame_start is sampled (bounded), gathering strobe statistics.
    task automatic b_frame(output int cyc, output int hs1, output int vs1, output int vb,
                           output bit saw1);
        cyc = 0; hs1 = 0; vs1 = 0; vb = 0; saw1 = 1'b0;
        ifb.pix_en = 1'b1;
        do begin
            @(negedge clk);
            cyc++;
            if (ifb.hsync) hs1++;
            if (ifb.vsync) vs1++;
            if (ifb.vblnk) vb++;
            if (!ifb.frame_start && ifb.active_mode) saw1 = 1'b1;
        end while (!ifb.frame_start && cyc < 1000);
    endtask

    typedef struct {
        bit en;
        int n;
        int eh;
        int ev;
        bit ehs;
        bit ehb;
    } avec_t;

    avec_t tbl [9];

    initial begin
        int  cyc, hs1, vs1, vb, nlow, nblk;
        bit  saw1;

        ca[0] = '{ha: 1024, ht: 1344, hss: 1048, hse: 1183, va: 768, vt: 806,
                  vss: 771, vse: 776, hp: 1'b0, vp: 1'b0};
        ca[1] = '{ha: 800, ht: 1056, hss: 840, hse: 967, va: 600, vt: 628,
                  vss: 601, vse: 604, hp: 1'b1, vp: 1'b1};
        cb[0] = '{ha: 16, ht: 24, hss: 18, hse: 20, va: 10, vt: 14,
                  vss: 11, vse: 12, hp: 1'b0, vp: 1'b0};
        cb[1] = '{ha: 12, ht: 20, hss: 13, hse: 15, va: 8, vt: 11,
                  vss: 9, vse: 9, hp: 1'b1, vp: 1'b1};

        tbl[0] = '{en: 1'b1, n: 1047, eh: 1047, ev: 0, ehs: 1'b1, ehb: 1'b1};
        tbl[1] = '{en: 1'b0, n: 10,   eh: 1047, ev: 0, ehs: 1'b1, ehb: 1'b1};
        tbl[2] = '{en: 1'b1, n: 1,    eh: 1048, ev: 0, ehs: 1'b0, ehb: 1'b1};
        tbl[3] = '{en: 1'b1, n: 135,  eh: 1183, ev: 0, ehs: 1'b0, ehb: 1'b1};
        tbl[4] = '{en: 1'b1, n: 1,    eh: 1184, ev: 0, ehs: 1'b1, ehb: 1'b1};
        tbl[5] = '{en: 1'b1, n: 159,  eh: 1343, ev: 0, ehs: 1'b1, ehb: 1'b1};
        tbl[6] = '{en: 1'b1, n: 1,    eh: 0,    ev: 1, ehs: 1'b1, ehb: 1'b0};
        tbl[7] = '{en: 1'b1, n: 1023, eh: 1023, ev: 1, ehs: 1'b1, ehb: 1'b0};
        tbl[8] = '{en: 1'b1, n: 1,    eh: 1024, ev: 1, ehs: 1'b1, ehb: 1'b1};

        ifa.pix_en = 1'b0; ifa.mode_sel = 1'b0;
        ifb.pix_en = 1'b0; ifb.mode_sel = 1'b0;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        chk_en = 1'b1;

        check("a_reset", {16'(ifa.hcount), 16'(ifa.vcount), ifa.hsync, ifa.vsync, ifa.hblnk,
                          ifa.vblnk, ifa.frame_start, ifa.active_mode}, {32'd0, 6'b110000});
        check("b_reset", {16'(ifb.hcount), 16'(ifb.vcount), ifb.hsync, ifb.vsync, ifb.hblnk,
                          ifb.vblnk, ifb.frame_start, ifb.active_mode}, {32'd0, 6'b110000});

        // Horizontal timing of the default instance, including a 10-cycle stall at 1047.
        for (int i = 0; i < 9; i++) begin
            run_a(tbl[i].en, tbl[i].n);
            check($sformatf("a_vec%0d", i),
                  {16'(ifa.hcount), 16'(ifa.vcount), ifa.hsync, ifa.hblnk, ifa.frame_start},
                  {16'(tbl[i].eh), 16'(tbl[i].ev), tbl[i].ehs, tbl[i].ehb, 1'b0});
        end

        nlow = 0; nblk = 0;
        ifa.pix_en = 1'b1;
        for (int i = 0; i < 1344; i++) begin
            @(negedge clk);
            if (!ifa.hsync) nlow++;
            if (ifa.hblnk) nblk++;
        end
        ifa.pix_en = 1'b0;
        check("a_hsync_width", 64'(nlow), 64'd136);
        check("a_hblnk_width", 64'(nblk), 64'd320);
        check("a_line_end", {16'(ifa.hcount), 16'(ifa.vcount)}, {16'd1024, 16'd2});

        // First frame in mode 0: first pulse at first wrap, not at reset release.
        b_frame(cyc, hs1, vs1, vb, saw1);
        check("b_f1_period", 64'(cyc), 64'd336);
        check("b_f1_hsync_hi", 64'(hs1), 64'd294);
        check("b_f1_vsync_hi", 64'(vs1), 64'd288);
        check("b_f1_vblnk", 64'(vb), 64'd96);

        // Switch request mid-frame takes effect only at the wrap.
        step_b(150);
        ifb.mode_sel = 1'b1;
        b_frame(cyc, hs1, vs1, vb, saw1);
        check("b_sw_period", 64'(cyc), 64'd186);
        check("b_sw_early", 64'(saw1), 64'd0);
        check("b_sw_wrap", {16'(ifb.hcount), 16'(ifb.vcount), ifb.hsync, ifb.vsync,
                            ifb.frame_start, ifb.active_mode}, {32'd0, 4'b0011});

        b_frame(cyc, hs1, vs1, vb, saw1);
        check("b_m1_period", 64'(cyc), 64'd220);
        check("b_m1_hsync_hi", 64'(hs1), 64'd33);
        check("b_m1_vsync_hi", 64'(vs1), 64'd20);
        check("b_m1_vblnk", 64'(vb), 64'd60);
        check("b_m1_mode", 64'(ifb.active_mode), 64'd1);

        ifb.mode_sel = 1'b0;
        b_frame(cyc, hs1, vs1, vb, saw1);
        check("b_back_period", 64'(cyc), 64'd220);
        check("b_back_mode", 64'(ifb.active_mode), 64'd0);

        // A 0->1->0 pulse inside one frame must be ignored.
        step_b(20);
        ifb.mode_sel = 1'b1;
        step_b(30);
        ifb.mode_sel = 1'b0;
        b_frame(cyc, hs1, vs1, vb, saw1);
        check("b_pulse_period", 64'(cyc), 64'd286);
        check("b_pulse_mode", {ifb.frame_start, ifb.active_mode}, 64'b10);

        // Asynchronous reset mid-frame while in mode 1 with mode_sel held at 1.
        ifb.mode_sel = 1'b1;
        b_frame(cyc, hs1, vs1, vb, saw1);
        check("b_pre_rst_mode", 64'(ifb.active_mode), 64'd1);
        step_b(100);
        #2 rst_b = 1'b1;
        #1 check("b_async_rst", {16'(ifb.hcount), 16'(ifb.vcount), ifb.hsync, ifb.vsync,
                                 ifb.active_mode}, {32'd0, 3'b110});
        @(negedge clk);
        rst_b = 1'b0;
        b_frame(cyc, hs1, vs1, vb, saw1);
        check("b_rst_period", 64'(cyc), 64'd336);
        check("b_rst_early", 64'(saw1), 64'd0);
        check("b_rst_mode", 64'(ifb.active_mode), 64'd1);

        // Random stalls and mode requests, checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            ifb.pix_en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0) ifb.mode_sel = ~ifb.mode_sel;
            @(negedge clk);
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
